bf_uart_tx: RTL and testbench



---
 rtl/bf_uart_pkg.sv | 17 +
 rtl/bf_byte_fifo.sv | 52 +++++
 rtl/bf_uart_tx.sv | 149 ++++++++++++++
 tb/tb_bf_uart_tx.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bf_uart_pkg.sv
// Shared UART line-format constants and tx state type for the brainfuck processor.
// The program-loading receiver imports the same constants so both ends agree on the frame.
package bf_uart_pkg;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;
  localparam logic UART_IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

endpackage

// File: rtl/bf_byte_fifo.sv
// Synchronous byte FIFO with registered occupancy count; push when full and
// pop when empty are ignored.
module bf_byte_fifo #(
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  sysClk,
  input  logic                  reset,
  input  logic [7:0]            pushData,
  input  logic                  push,
  input  logic                  pop,
  output logic [7:0]            popData,
  output logic                  full,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [7:0]            mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic                  doPush;
  logic                  doPop;

  assign full    = (count == (ADDR_WIDTH + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign doPush  = push & ~full;
  assign doPop   = pop & ~empty;
  assign popData = mem[rdPtr];

  always_ff @(posedge sysClk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: contents are only visible through a valid count.
  always_ff @(posedge sysClk) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/bf_uart_tx.sv
// 8N1 (or 8N2) UART transmitter for the processor's `.` output, fed by a byte FIFO.
//   state | meaning
//   IDLE  | line high, waiting for a queued byte
//   START | start bit (low) for one bit period
//   DATA  | eight data bits, LSB first
//   STOP  | stop bit(s) high; pops the next byte with no gap if one is queued
module bf_uart_tx
  import bf_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT    = 16,
  parameter int FIFO_ADDR_WIDTH = 2,
  parameter int STOP_BITS       = 1
) (
  input  logic                       sysClk,
  input  logic                       reset,
  input  logic [7:0]                 dataIn,
  input  logic                       dataValid,
  output logic                       dataReady,
  output logic                       tx,
  output logic                       busy,
  output logic [FIFO_ADDR_WIDTH:0]   fifoCount
);

  localparam int DIV_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_DATA = 3'(UART_DATA_BITS - 1);
  localparam logic [2:0]       LAST_STOP = 3'(STOP_BITS - 1);

  txState_t         state;
  txState_t         stateNext;
  logic [DIV_W-1:0] divider;
  logic [DIV_W-1:0] dividerNext;
  logic [2:0]       bitIdx;
  logic [2:0]       bitIdxNext;
  logic [7:0]       shiftReg;
  logic [7:0]       shiftNext;
  logic             txNext;
  logic             fifoPop;
  logic             fifoFull;
  logic             fifoEmpty;
  logic [7:0]       fifoHead;
  logic             bitBoundary;

  assign dataReady   = ~fifoFull;
  assign busy        = (state != IDLE) | (fifoCount != '0);
  assign bitBoundary = (divider == DIV_LAST);

  bf_byte_fifo #(
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) uFifo (
    .sysClk   (sysClk),
    .reset    (reset),
    .pushData (dataIn),
    .push     (dataValid & dataReady),
    .pop      (fifoPop),
    .popData  (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  always_comb begin
    stateNext   = state;
    dividerNext = divider;
    bitIdxNext  = bitIdx;
    shiftNext   = shiftReg;
    fifoPop     = 1'b0;
    case (state)
      IDLE: begin
        dividerNext = '0;
        bitIdxNext  = '0;
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shiftNext = fifoHead;
          stateNext = START;
        end
      end
      START: begin
        if (bitBoundary) begin
          dividerNext = '0;
          bitIdxNext  = '0;
          stateNext   = DATA;
        end else begin
          dividerNext = divider + 1'b1;
        end
      end
      DATA: begin
        if (bitBoundary) begin
          dividerNext = '0;
          shiftNext   = {1'b0, shiftReg[7:1]};
          if (bitIdx == LAST_DATA) begin
            bitIdxNext = '0;
            stateNext  = STOP;
          end else begin
            bitIdxNext = bitIdx + 1'b1;
          end
        end else begin
          dividerNext = divider + 1'b1;
        end
      end
      STOP: begin
        if (bitBoundary) begin
          dividerNext = '0;
          if (bitIdx == LAST_STOP) begin
            bitIdxNext = '0;
            if (!fifoEmpty) begin
              fifoPop   = 1'b1;
              shiftNext = fifoHead;
              stateNext = START;
            end else begin
              stateNext = IDLE;
            end
          end else begin
            bitIdxNext = bitIdx + 1'b1;
          end
        end else begin
          dividerNext = divider + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // Line level follows the next state so tx changes on the same edge as the FSM.
  always_comb begin
    case (stateNext)
      START:   txNext = UART_START_LEVEL;
      DATA:    txNext = shiftNext[0];
      default: txNext = UART_STOP_LEVEL;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (reset) begin
      state    <= IDLE;
      divider  <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      tx       <= UART_IDLE_LEVEL;
    end else begin
      state    <= stateNext;
      divider  <= dividerNext;
      bitIdx   <= bitIdxNext;
      shiftReg <= shiftNext;
      tx       <= txNext;
    end
  end

endmodule

// File: tb/tb_bf_uart_tx.sv
// Self-checking bench for bf_uart_tx: table-driven frames, a line decoder as reference
// model, hand sequences for FIFO full / back-to-back / reset / two stop bits.
module tb_bf_uart_tx;

  localparam int CPB = 4;

  logic       sysClk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] dataIn = 8'h00;
  logic       dataValid = 1'b0;
  logic       dataReady;
  logic       tx;
  logic       busy;
  logic [2:0] fifoCount;

  logic [7:0] dataIn2 = 8'h00;
  logic       dataValid2 = 1'b0;
  logic       dataReady2;
  logic       tx2;
  logic       busy2;
  logic [2:0] fifoCount2;

  int nChecks = 0;
  int nFail = 0;
  int cyc = 0;

  always #5 sysClk = ~sysClk;
  always @(posedge sysClk) cyc <= cyc + 1;

  bf_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_WIDTH(2), .STOP_BITS(1)) dut (
    .sysClk(sysClk), .reset(reset), .dataIn(dataIn), .dataValid(dataValid),
    .dataReady(dataReady), .tx(tx), .busy(busy), .fifoCount(fifoCount));

  bf_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_ADDR_WIDTH(2), .STOP_BITS(2)) dut2 (
    .sysClk(sysClk), .reset(reset), .dataIn(dataIn2), .dataValid(dataValid2),
    .dataReady(dataReady2), .tx(tx2), .busy(busy2), .fifoCount(fifoCount2));

  // Line decoder: finds a falling edge, samples each bit mid-period, queues the byte.
  logic [7:0] rxQ[$];
  int         startQ[$];
  logic [9:0] monBits;
  bit         monBusy = 1'b0;
  int         monT = 0;
  int         framingErr = 0;
  int         maxCount = 0;

  always @(negedge sysClk) begin
    if (int'(fifoCount) > maxCount) maxCount = int'(fifoCount);
    if (reset) begin
      monBusy = 1'b0;
    end else if (!monBusy) begin
      if (tx === 1'b0) begin
        monBusy = 1'b1;
        monT = 0;
        startQ.push_back(cyc);
      end
    end else begin
      monT++;
      if (monT % CPB == CPB / 2) begin
        monBits[monT / CPB] = tx;
        if (monT / CPB == 9) begin
          if (monBits[0] !== 1'b0 || monBits[9] !== 1'b1) framingErr++;
          rxQ.push_back(monBits[8:1]);
          monBusy = 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    while ((busy !== 1'b0 || monBusy) && n < budget) begin
      @(negedge sysClk);
      n++;
    end
    check("idle_within_budget", 32'(n < budget), 32'd1);
    repeat (2) @(negedge sysClk);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;  // bit 0 = start bit, bit 9 = stop bit
  } vec_t;

  vec_t vecs[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] full6[6];
    int         sentAt[6];
    logic [7:0] accQ[$];
    int         base;
    int         sBase;
    int         n;
    int         i;
    bit         rdy;
    int         lowSeen;
    int         h;

    vecs[0] = '{8'h2B, 10'b1001010110};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};

    repeat (3) @(negedge sysClk);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ready", dataReady, 1);
    check("rst_count", fifoCount, 0);
    check("rst_ready2", dataReady2, 1);
    check("rst_count2", fifoCount2, 0);
    reset = 1'b0;
    repeat (2) @(negedge sysClk);

    // Single-byte frames, sampled mid-bit
    base = rxQ.size();
    foreach (vecs[v]) begin
      @(negedge sysClk);
      dataIn = vecs[v].data;
      dataValid = 1'b1;
      @(negedge sysClk);
      dataValid = 1'b0;
      dataIn = ~vecs[v].data;
      check("push_count", fifoCount, 1);
      check("tx_before_pop", tx, 1);
      @(negedge sysClk);
      check("tx_fall", tx, 0);
      check("pop_count", fifoCount, 0);
      repeat (CPB / 2) @(negedge sysClk);
      for (int k = 0; k < 10; k++) begin
        check($sformatf("frame%0d_bit%0d", v, k), tx, vecs[v].frame[k]);
        if (k < 9) repeat (CPB) @(negedge sysClk);
      end
      repeat (CPB / 2 - 1) @(negedge sysClk);
      check("busy_last_stop_cycle", busy, 1);
      @(negedge sysClk);
      check("busy_after_frame", busy, 0);
      check("tx_idle", tx, 1);
    end
    check("vec_rx_count", rxQ.size(), base + 4);
    if (rxQ.size() == base + 4)
      foreach (vecs[v]) check("vec_rx_byte", rxQ[base + v], vecs[v].data);
    waitIdle(100);

    // Back-to-back, second push coincides with the IDLE pop
    base = rxQ.size();
    sBase = startQ.size();
    @(negedge sysClk);
    dataIn = 8'h5B;
    dataValid = 1'b1;
    @(negedge sysClk);
    dataIn = 8'h5D;
    @(negedge sysClk);
    dataValid = 1'b0;
    check("simul_pushpop_count", fifoCount, 1);
    waitIdle(200);
    check("b2b_rx_count", rxQ.size(), base + 2);
    check("b2b_start_count", startQ.size(), sBase + 2);
    if (rxQ.size() == base + 2) begin
      check("b2b_byte0", rxQ[base], 8'h5B);
      check("b2b_byte1", rxQ[base + 1], 8'h5D);
    end
    if (startQ.size() == sBase + 2)
      check("b2b_gap", startQ[sBase + 1] - startQ[sBase], 10 * CPB);

    // Full FIFO: six bytes offered continuously
    base = rxQ.size();
    full6 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    i = 0;
    n = 0;
    @(negedge sysClk);
    dataIn = full6[0];
    dataValid = 1'b1;
    while (i < 6 && n < 200) begin
      rdy = dataReady;
      @(negedge sysClk);
      n++;
      if (rdy) begin
        sentAt[i] = n;
        i++;
        if (i == 5) begin
          check("full_ready_low", dataReady, 0);
          check("full_count", fifoCount, 4);
        end
        if (i < 6) dataIn = full6[i];
        else dataValid = 1'b0;
      end
    end
    dataValid = 1'b0;
    check("full_all_accepted", i, 6);
    if (i == 6) begin
      check("full_fifth_edge", sentAt[4], 5);
      check("full_sixth_edge", sentAt[5], 43);
    end
    waitIdle(400);
    check("full_rx_count", rxQ.size(), base + 6);
    if (rxQ.size() == base + 6)
      for (int k = 0; k < 6; k++) check("full_order", rxQ[base + k], full6[k]);

    // Randomized traffic against the decoded line
    base = rxQ.size();
    n = 0;
    while (accQ.size() < 24 && n < 3000) begin
      @(negedge sysClk);
      dataIn = 8'($urandom);
      dataValid = 1'($urandom_range(0, 1));
      rdy = dataReady;
      @(negedge sysClk);
      n++;
      if (dataValid && rdy) accQ.push_back(dataIn);
      dataValid = 1'b0;
    end
    check("rand_accepted", accQ.size(), 24);
    waitIdle(24 * 10 * CPB + 200);
    check("rand_rx_count", rxQ.size(), base + accQ.size());
    if (rxQ.size() == base + accQ.size())
      foreach (accQ[k]) check("rand_byte", rxQ[base + k], accQ[k]);
    check("framing_errors", framingErr, 0);
    check("max_fifo_count", maxCount, 4);

    // Reset during DATA bit 3 with two bytes queued
    @(negedge sysClk);
    dataIn = 8'hA1;
    dataValid = 1'b1;
    @(negedge sysClk);
    dataIn = 8'hA2;
    @(negedge sysClk);
    dataIn = 8'hA3;
    @(negedge sysClk);
    dataValid = 1'b0;
    check("rst_mid_queued", fifoCount, 2);
    repeat (4 * CPB) @(negedge sysClk);
    check("rst_mid_bit3", tx, 0);
    reset = 1'b1;
    @(negedge sysClk);
    check("rst_mid_tx", tx, 1);
    check("rst_mid_count", fifoCount, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", dataReady, 1);
    @(negedge sysClk);
    reset = 1'b0;
    base = rxQ.size();
    lowSeen = 0;
    repeat (100) begin
      @(negedge sysClk);
      if (tx !== 1'b1) lowSeen++;
    end
    check("rst_no_frames_line", lowSeen, 0);
    check("rst_no_frames_rx", rxQ.size(), base);
    check("rst_still_idle", busy, 0);

    // Two stop bits on the second instance
    @(negedge sysClk);
    dataIn2 = 8'hFF;
    dataValid2 = 1'b1;
    @(negedge sysClk);
    dataIn2 = 8'h00;
    @(negedge sysClk);
    dataValid2 = 1'b0;
    check("sb2_start", tx2, 0);
    n = 0;
    while (tx2 === 1'b0 && n < 50) begin
      n++;
      @(negedge sysClk);
    end
    check("sb2_start_len", n, CPB);
    h = 0;
    while (tx2 === 1'b1 && h < 100) begin
      h++;
      @(negedge sysClk);
    end
    check("sb2_high_len", h, 8 * CPB + 2 * CPB);
    n = 0;
    while (busy2 !== 1'b0 && n < 200) begin
      n++;
      @(negedge sysClk);
    end
    check("sb2_idle", busy2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
